pixel_write_arbiter: RTL and testbench

- Shares the single write port of the framebuffer `memory` instance between NUM_REQ Mandelbrot iteration cores.
- Each core presents a pixel address and iteration count on a valid/ready handshake.
- The block grants one core per cycle in round-robin order and drives a registered write onto the memory write port.
- It also counts committed pixel writes and pulses frame_done when a full frame has been written.

---
 rtl/pixel_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_pixel_write_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter
//   Shares the single framebuffer write port between NUM_REQ iteration cores.
//   Cores are granted round-robin, one per cycle, and the winning request is
//   registered onto the memory write port. Committed writes are counted per
//   frame and frame_done pulses with the last write of each frame.
//
// Ports
//   clk          single clock; also drives the memory write clock
//   reset_n      asynchronous active-low reset
//   enable       grants are issued only while high
//   clear        synchronous frame restart (count and pointer to zero)
//   req_valid    per-core request
//   req_addr     flattened per-core address, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data     flattened per-core pixel word, same packing
//   req_ready    one-hot combinational grant
//   write_en     registered memory write enable
//   write_addr   registered memory write address
//   write_data   registered memory write data
//   write_src    registered id of the core that was written
//   write_count  pixels committed in the current frame
//   frame_done   one-cycle pulse coincident with the last write of a frame
module pixel_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int WORD_SIZE   = 8,
    parameter int FRAME_WORDS = 256,
    parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          write_en,
    output logic [ADDR_WIDTH-1:0]         write_addr,
    output logic [WORD_SIZE-1:0]          write_data,
    output logic [ID_WIDTH-1:0]           write_src,
    output logic [ADDR_WIDTH:0]           write_count,
    output logic                          frame_done
);

    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(FRAME_WORDS - 1);
    localparam logic [ID_WIDTH:0]   NUM_EXT  = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(NUM_REQ - 1);

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [WORD_SIZE-1:0]  data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[g] = req_data[g*WORD_SIZE +: WORD_SIZE];
    end

    logic                  we_q,    we_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [WORD_SIZE-1:0]  data_q,  data_d;
    logic [ID_WIDTH-1:0]   src_q,   src_d;
    logic [ADDR_WIDTH:0]   cnt_q,   cnt_d;
    logic                  done_q,  done_d;
    logic [ID_WIDTH-1:0]   ptr_q,   ptr_d;

    logic                  grant_vld;
    logic [ID_WIDTH-1:0]   grant_id;

    // Circular search from the pointer. The index runs over ptr..ptr+NUM_REQ-1
    // and is folded back below NUM_REQ, which also covers non-power-of-two
    // core counts. Gating with reset_n keeps req_ready low during reset.
    always_comb begin
        logic [ID_WIDTH:0] idx;
        logic [ID_WIDTH:0] wrapped;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        wrapped   = '0;
        if (reset_n && enable && !clear) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx     = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
                wrapped = (idx >= NUM_EXT) ? idx - NUM_EXT : idx;
                if (!grant_vld && req_valid[wrapped[ID_WIDTH-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_id  = wrapped[ID_WIDTH-1:0];
                end
            end
        end
    end

    assign req_ready = {{(NUM_REQ-1){1'b0}}, grant_vld} << grant_id;

    always_comb begin
        we_d   = 1'b0;
        done_d = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        src_d  = src_q;
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        if (clear) begin
            cnt_d = '0;
            ptr_d = '0;
        end else if (grant_vld) begin
            we_d   = 1'b1;
            addr_d = addr_arr[grant_id];
            data_d = data_arr[grant_id];
            src_d  = grant_id;
            ptr_d  = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            if (cnt_q == LAST_CNT) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            src_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            ptr_q  <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            src_q  <= src_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            ptr_q  <= ptr_d;
        end
    end

    assign write_en    = we_q;
    assign write_addr  = addr_q;
    assign write_data  = data_q;
    assign write_src   = src_q;
    assign write_count = cnt_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: two instances share stimulus, one with a
// 256-word frame and one with a 4-word frame so frame wrap is exercised often.
module tb_pixel_write_arbiter;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic            clear;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;

    logic [N-1:0]  rdy_a,  rdy_b;
    logic          we_a,   we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic [IDW-1:0] src_a, src_b;
    logic [AW:0]   cnt_a,  cnt_b;
    logic          fd_a,   fd_b;

    pixel_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .WORD_SIZE(DW), .FRAME_WORDS(256)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(rdy_a), .write_en(we_a), .write_addr(addr_a), .write_data(data_a),
        .write_src(src_a), .write_count(cnt_a), .frame_done(fd_a));

    pixel_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .WORD_SIZE(DW), .FRAME_WORDS(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(rdy_b), .write_en(we_b), .write_addr(addr_b), .write_data(data_b),
        .write_src(src_b), .write_count(cnt_b), .frame_done(fd_b));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what the memory port should show after each cycle.
    int m_ptr, m_cnt_a, m_cnt_b, m_addr, m_data, m_src;
    bit m_we, m_fd_a, m_fd_b;

    function automatic void model_reset();
        m_ptr = 0; m_cnt_a = 0; m_cnt_b = 0;
        m_addr = 0; m_data = 0; m_src = 0;
        m_we = 0; m_fd_a = 0; m_fd_b = 0;
    endfunction

    function automatic int pick();
        if (!enable || clear) return -1;
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_regs();
        chk("we_a",   we_a,   m_we);
        chk("we_b",   we_b,   m_we);
        chk("addr_a", addr_a, m_addr);
        chk("addr_b", addr_b, m_addr);
        chk("data_a", data_a, m_data);
        chk("src_a",  src_a,  m_src);
        chk("src_b",  src_b,  m_src);
        chk("cnt_a",  cnt_a,  m_cnt_a);
        chk("cnt_b",  cnt_b,  m_cnt_b);
        chk("fd_a",   fd_a,   m_fd_a);
        chk("fd_b",   fd_b,   m_fd_b);
    endtask

    // Called at a negedge: apply inputs, check the grant, step the model,
    // then check the registered outputs at the following negedge.
    task automatic cycle(input logic [N-1:0] v, input logic en, input logic clr);
        int g;
        req_valid = v; enable = en; clear = clr;
        #1;
        g = pick();
        chk("rdy_a", rdy_a, (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("rdy_b", rdy_b, (g >= 0) ? (32'd1 << g) : 32'd0);
        if (clr) begin
            m_cnt_a = 0; m_cnt_b = 0; m_ptr = 0;
            m_we = 0; m_fd_a = 0; m_fd_b = 0;
        end else if (g >= 0) begin
            m_we   = 1;
            m_addr = int'(req_addr[g*AW +: AW]);
            m_data = int'(req_data[g*DW +: DW]);
            m_src  = g;
            m_ptr  = (g + 1) % N;
            m_fd_a = (m_cnt_a == 255);
            m_fd_b = (m_cnt_b == 3);
            m_cnt_a = (m_cnt_a + 1) % 256;
            m_cnt_b = (m_cnt_b + 1) % 4;
        end else begin
            m_we = 0; m_fd_a = 0; m_fd_b = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_regs();
    endtask

    task automatic randomize_bus();
        req_addr = 32'($urandom);
        req_data = 32'($urandom);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; clear = 1'b0;
        req_valid = '1; req_addr = '0; req_data = '0;
        model_reset();
        #2;
        chk("rdy_in_reset", rdy_a, 0);
        check_regs();
        @(negedge clk);
        reset_n = 1'b1;
        req_valid = '0;

        // single request from core 0
        req_addr[0 +: AW] = 8'h12;
        req_data[0 +: DW] = 8'h34;
        cycle(4'b0001, 1'b1, 1'b0);
        chk("first_addr", addr_a, 8'h12);
        chk("first_data", data_a, 8'h34);
        chk("first_cnt",  cnt_a,  1);

        // all cores valid for 8 cycles after a clear
        cycle(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            randomize_bus();
            cycle(4'b1111, 1'b1, 1'b0);
            chk("rr_src", src_a, i % 4);
        end
        chk("rr_cnt8", cnt_a, 8);

        // pointer at 2, valid=1011
        cycle(4'b0010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            randomize_bus();
            cycle(4'b1011, 1'b1, 1'b0);
        end
        chk("skip2_src", src_a, 1);

        // 4-word frame wrap
        cycle(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(4'b0001, 1'b1, 1'b0);
        chk("frame_done_4", fd_b, 1);
        chk("frame_cnt_0",  cnt_b, 0);
        cycle(4'b0001, 1'b1, 1'b0);
        chk("frame_done_5", fd_b, 0);
        chk("frame_cnt_1",  cnt_b, 1);

        // clear together with requests after 3 writes
        cycle(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1, 1'b0);
        cycle(4'b1111, 1'b1, 1'b1);
        chk("clr_cnt", cnt_a, 0);
        cycle(4'b1111, 1'b1, 1'b0);
        chk("clr_src0", src_a, 0);

        // enable low: nothing granted, state holds
        for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            randomize_bus();
            cycle(4'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0));
        end

        // reset mid-stream while a write is in flight
        cycle(4'b1111, 1'b1, 1'b0);
        chk("pre_reset_we", we_a, 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_rdy", rdy_a, 0);
        check_regs();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(4'b0110, 1'b1, 1'b0);
        chk("post_reset_src", src_a, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
